window_actuator_ctrl: RTL and testbench

//  Receives the per-window close commands from the weather alarm (window_close_cmd) and

---
 rtl/window_actuator_ctrl.sv | 162 ++++++++++++++++
 tb/tb_window_actuator_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/window_actuator_ctrl.sv
// Window motor controller: per-window OPEN/CLOSING/CLOSED/OPENING/FAULT FSMs sharing one motor driver.
// Optional macro OBSTRUCTION_REVERSE_EN enables reversal of a closing window on obstruction.
module window_actuator_ctrl #(
    parameter int NUM_WIN        = 8,
    parameter int TRAVEL_TIMEOUT = 1000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_WIN-1:0] window_close_cmd,
    input  logic [NUM_WIN-1:0] open_req,
    input  logic [NUM_WIN-1:0] limit_closed,
    input  logic [NUM_WIN-1:0] limit_open,
    input  logic [NUM_WIN-1:0] obstruction,
    input  logic [NUM_WIN-1:0] fault_clr,
    output logic [NUM_WIN-1:0] motor_close,
    output logic [NUM_WIN-1:0] motor_open,
    output logic [NUM_WIN-1:0] windowState,
    output logic [NUM_WIN-1:0] fault,
    output logic               busy
);

    localparam int PW = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1;
    localparam int CW = $clog2(TRAVEL_TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_OPEN,
        ST_CLOSING,
        ST_CLOSED,
        ST_OPENING,
        ST_FAULT
    } win_state_t;

    win_state_t         state_q [NUM_WIN];
    win_state_t         state_d [NUM_WIN];
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [NUM_WIN-1:0] is_closing, is_opening, req, reverse, lock;
    logic               pause, moving, grant_vld;
    logic [PW-1:0]      grant_idx, cand;

`ifdef OBSTRUCTION_REVERSE_EN
    logic               pause_q;
    logic [NUM_WIN-1:0] lock_q;

    // Reversal inserts one motor-off cycle; the lock holds off re-closing until the frame is clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pause_q <= 1'b0;
            lock_q  <= '0;
        end else begin
            pause_q <= |reverse;
            lock_q  <= reverse | (lock_q & obstruction);
        end
    end

    assign pause   = pause_q;
    assign lock    = lock_q;
    assign reverse = is_closing & obstruction & ~limit_closed;
`else
    logic unused_obstruction;
    assign unused_obstruction = ^obstruction;
    assign pause   = 1'b0;
    assign lock    = '0;
    assign reverse = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_WIN; i++) state_q[i] <= ST_OPEN;
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < NUM_WIN; i++) state_q[i] <= state_d[i];
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    // Requests and round-robin search; nothing is granted while any window is moving.
    always_comb begin
        for (int i = 0; i < NUM_WIN; i++) begin
            is_closing[i] = (state_q[i] == ST_CLOSING);
            is_opening[i] = (state_q[i] == ST_OPENING);
            req[i] = ((state_q[i] == ST_OPEN) && window_close_cmd[i] && !limit_closed[i] && !lock[i])
                  || ((state_q[i] == ST_CLOSED) && open_req[i] && !window_close_cmd[i]
                      && !(limit_open[i] && limit_closed[i]));
        end
        moving    = |(is_closing | is_opening);
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_WIN; k++) begin
            cand = PW'((int'(ptr_q) + k) % NUM_WIN);
            if (!moving && !grant_vld && req[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
        ptr_d = grant_vld ? grant_idx : ptr_q;
    end

    // Per-window next state; the timeout fires as the counter reaches the limit.
    always_comb begin
        for (int i = 0; i < NUM_WIN; i++) begin
            state_d[i] = state_q[i];
            if (limit_open[i] && limit_closed[i]) begin
                state_d[i] = ST_FAULT;
            end else begin
                case (state_q[i])
                    ST_OPEN: begin
                        if (limit_closed[i])
                            state_d[i] = ST_CLOSED;
                        else if (grant_vld && grant_idx == PW'(i))
                            state_d[i] = ST_CLOSING;
                    end
                    ST_CLOSED: begin
                        if (grant_vld && grant_idx == PW'(i))
                            state_d[i] = ST_OPENING;
                    end
                    ST_CLOSING: begin
                        if (limit_closed[i])
                            state_d[i] = ST_CLOSED;
                        else if (reverse[i])
                            state_d[i] = ST_OPENING;
                        else if (count_q == CW'(TRAVEL_TIMEOUT - 1))
                            state_d[i] = ST_FAULT;
                    end
                    ST_OPENING: begin
                        if (limit_open[i])
                            state_d[i] = ST_OPEN;
                        else if (!pause && count_q == CW'(TRAVEL_TIMEOUT - 1))
                            state_d[i] = ST_FAULT;
                    end
                    ST_FAULT: begin
                        if (fault_clr[i])
                            state_d[i] = ST_OPEN;
                    end
                    default: state_d[i] = ST_OPEN;
                endcase
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (grant_vld || (|reverse))
            count_d = '0;
        else if (moving && !pause && count_q != CW'(TRAVEL_TIMEOUT))
            count_d = count_q + CW'(1);
    end

    always_comb begin
        for (int i = 0; i < NUM_WIN; i++) begin
            motor_close[i] = is_closing[i];
            motor_open[i]  = is_opening[i] && !pause;
            windowState[i] = (state_q[i] != ST_CLOSED);
            fault[i]       = (state_q[i] == ST_FAULT);
        end
        busy = |(motor_close | motor_open);
    end

endmodule

// File: tb/tb_window_actuator_ctrl.sv
// Scoreboard bench for window_actuator_ctrl (TRAVEL_TIMEOUT=16); expected outputs queued per stimulus step.
// Reversal expectations follow OBSTRUCTION_REVERSE_EN when that macro is defined.
module tb_window_actuator_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] window_close_cmd, open_req, limit_closed, limit_open, obstruction, fault_clr;
    logic [7:0] motor_close, motor_open, windowState, fault;
    logic       busy;

    typedef struct {
        logic [7:0] mc;
        logic [7:0] mo;
        logic [7:0] ws;
        logic [7:0] ft;
        logic       bz;
    } exp_t;

    exp_t  sb [$];
    string tag_q [$];
    int    vectors = 0;
    int    miscompares = 0;

    window_actuator_ctrl #(.NUM_WIN(8), .TRAVEL_TIMEOUT(16)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .window_close_cmd(window_close_cmd),
        .open_req(open_req),
        .limit_closed(limit_closed),
        .limit_open(limit_open),
        .obstruction(obstruction),
        .fault_clr(fault_clr),
        .motor_close(motor_close),
        .motor_open(motor_open),
        .windowState(windowState),
        .fault(fault),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Expected outputs for the cycle after this step's inputs are sampled.
    task automatic applyStimulus(input string tag, input logic [7:0] mc, input logic [7:0] mo,
                                 input logic [7:0] ws, input logic [7:0] ft);
        exp_t  e;
        string t;
        sb.push_back('{mc, mo, ws, ft, |(mc | mo)});
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        t = tag_q.pop_front();
        checkOutput({t, ".motor_close"}, {24'h0, motor_close}, {24'h0, e.mc});
        checkOutput({t, ".motor_open"},  {24'h0, motor_open},  {24'h0, e.mo});
        checkOutput({t, ".windowState"}, {24'h0, windowState}, {24'h0, e.ws});
        checkOutput({t, ".fault"},       {24'h0, fault},       {24'h0, e.ft});
        checkOutput({t, ".busy"},        {31'h0, busy},        {31'h0, e.bz});
    endtask

    task automatic clearInputs();
        window_close_cmd = '0;
        open_req         = '0;
        limit_closed     = '0;
        limit_open       = '0;
        obstruction      = '0;
        fault_clr        = '0;
    endtask

    task automatic doReset(input string tag);
        clearInputs();
        rst_n = 1'b0;
        #1;
        checkOutput({tag, ".motor_close"}, {24'h0, motor_close}, 32'h0);
        checkOutput({tag, ".motor_open"},  {24'h0, motor_open},  32'h0);
        checkOutput({tag, ".windowState"}, {24'h0, windowState}, 32'hFF);
        checkOutput({tag, ".fault"},       {24'h0, fault},       32'h0);
        checkOutput({tag, ".busy"},        {31'h0, busy},        32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        doReset("reset0");

        // Round-robin from pointer 0 starts at window 1, so window 2 wins over window 0
        window_close_cmd = 8'h05;
        applyStimulus("s1_grant2", 8'h04, 8'h00, 8'hFF, 8'h00);
        repeat (2) applyStimulus("s1_move2", 8'h04, 8'h00, 8'hFF, 8'h00);
        limit_closed = 8'h04;
        applyStimulus("s1_done2", 8'h00, 8'h00, 8'hFB, 8'h00);
        applyStimulus("s1_grant0", 8'h01, 8'h00, 8'hFB, 8'h00);
        applyStimulus("s1_move0", 8'h01, 8'h00, 8'hFB, 8'h00);
        limit_closed = 8'h05;
        applyStimulus("s1_done0", 8'h00, 8'h00, 8'hFA, 8'h00);
        applyStimulus("s1_idle", 8'h00, 8'h00, 8'hFA, 8'h00);

        open_req = 8'h04;
        applyStimulus("s4_closewins", 8'h00, 8'h00, 8'hFA, 8'h00);
        window_close_cmd = 8'h01;
        applyStimulus("s4_open2", 8'h00, 8'h04, 8'hFE, 8'h00);
        open_req     = 8'h00;
        limit_closed = 8'h01;
        applyStimulus("s4_move", 8'h00, 8'h04, 8'hFE, 8'h00);
        limit_open = 8'h04;
        applyStimulus("s4_done", 8'h00, 8'h00, 8'hFE, 8'h00);
        applyStimulus("s4_idle", 8'h00, 8'h00, 8'hFE, 8'h00);

        doReset("reset2");
        window_close_cmd = 8'h81;
        applyStimulus("s2_grant7", 8'h80, 8'h00, 8'hFF, 8'h00);
        window_close_cmd = 8'h01;
        applyStimulus("s2_cmddrop", 8'h80, 8'h00, 8'hFF, 8'h00);
        limit_closed = 8'h80;
        applyStimulus("s2_done7", 8'h00, 8'h00, 8'h7F, 8'h00);
        applyStimulus("s2_grant0", 8'h01, 8'h00, 8'h7F, 8'h00);
        limit_closed = 8'h81;
        applyStimulus("s2_done0", 8'h00, 8'h00, 8'h7E, 8'h00);

        doReset("reset3");
        window_close_cmd = 8'h08;
        for (int k = 0; k < 16; k++) applyStimulus("s3_travel", 8'h08, 8'h00, 8'hFF, 8'h00);
        applyStimulus("s3_fault", 8'h00, 8'h00, 8'hFF, 8'h08);
        applyStimulus("s3_hold", 8'h00, 8'h00, 8'hFF, 8'h08);
        fault_clr = 8'h08;
        applyStimulus("s3_clear", 8'h00, 8'h00, 8'hFF, 8'h00);
        fault_clr = 8'h00;
        applyStimulus("s3_retry", 8'h08, 8'h00, 8'hFF, 8'h00);
        limit_closed = 8'h08;
        applyStimulus("s3_done", 8'h00, 8'h00, 8'hF7, 8'h00);

        doReset("reset5");
        limit_open   = 8'h10;
        limit_closed = 8'h10;
        applyStimulus("s5_bothlim", 8'h00, 8'h00, 8'hFF, 8'h10);
        limit_open   = 8'h00;
        limit_closed = 8'h00;
        fault_clr    = 8'h10;
        applyStimulus("s5_clear", 8'h00, 8'h00, 8'hFF, 8'h00);
        fault_clr        = 8'h00;
        window_close_cmd = 8'h02;
        applyStimulus("s5_grant1", 8'h02, 8'h00, 8'hFF, 8'h00);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("s5_async.motor_close", {24'h0, motor_close}, 32'h0);
        checkOutput("s5_async.motor_open",  {24'h0, motor_open},  32'h0);
        checkOutput("s5_async.busy",        {31'h0, busy},        32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        applyStimulus("s6_grant1", 8'h02, 8'h00, 8'hFF, 8'h00);
        obstruction = 8'h02;
`ifdef OBSTRUCTION_REVERSE_EN
        applyStimulus("s6_pause", 8'h00, 8'h00, 8'hFF, 8'h00);
        applyStimulus("s6_reopen", 8'h00, 8'h02, 8'hFF, 8'h00);
        obstruction = 8'h00;
        limit_open  = 8'h02;
        applyStimulus("s6_opened", 8'h00, 8'h00, 8'hFF, 8'h00);
`else
        applyStimulus("s6_keep1", 8'h02, 8'h00, 8'hFF, 8'h00);
        applyStimulus("s6_keep2", 8'h02, 8'h00, 8'hFF, 8'h00);
        obstruction = 8'h00;
        limit_open  = 8'h02;
        applyStimulus("s6_keep3", 8'h02, 8'h00, 8'hFF, 8'h00);
`endif
        applyStimulus("s6_closing", 8'h02, 8'h00, 8'hFF, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
